hazard_ctrl_multi: RTL and testbench
====================================

# hazard_ctrl_multi

Parametrised data-hazard controller for the pipelined core: per-source forwarding selects for the EX-stage ALU operands, a multi-cycle load-use stall sequencer, and a register scoreboard for long-latency (multiply/divide) results. It sits beside the ID/EX register and drives the EX operand muxes, the PC/IF-ID hold, and the ID/EX bubble insert.

## Interface
- NUM_SRC, 2, source operands per instruction (1..4)
- AW, 5, register address width; register file has 2**AW entries, entry 0 hard-wired zero
- LOAD_STALL, 1, stall cycles inserted on a load-use hit (1..7)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_mem_we / ex_mem_waddr  in  1 / AW  EX/MEM writeback enable and address
- mem_wb_we / mem_wb_waddr  in  1 / AW  MEM/WB writeback enable and address
- wb_we / wb_waddr  in  1 / AW  register-file write port this cycle
- id_ex_raddr  in  NUM_SRC*AW  EX-stage source addresses, source i at [i*AW +: AW]
- id_ex_we / id_ex_is_load / id_ex_waddr  in  1 / 1 / AW  EX-stage destination info
- if_id_raddr  in  NUM_SRC*AW  ID-stage source addresses
- if_id_rvalid  in  NUM_SRC  ID-stage source i actually read
- if_id_we / if_id_waddr  in  1 / AW  ID-stage destination
- mdu_issue / mdu_waddr  in  1 / AW  long-latency op leaves ID this cycle
- mdu_done / mdu_done_addr  in  1 / AW  long-latency result written this cycle
- flush  in  1  taken branch/jump kills IF/ID
- forward  out  NUM_SRC*2  per-source select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- busy  out  2**AW  scoreboard vector

## Operation
- Forwarding (combinational, per source i): priority EX/MEM > MEM/WB > WB; a stage matches when its we=1, its addr != 0 and addr == id_ex source i; else 00.
- load_hit: id_ex_we & id_ex_is_load & id_ex_waddr != 0 & (for some i, if_id_rvalid[i] & if_id_raddr[i] == id_ex_waddr).
- sb_hit: for some valid i, busy[if_id_raddr[i]]; or if_id_we & if_id_waddr != 0 & busy[if_id_waddr] (WAW).
- Sequencer states IDLE, LOAD_WAIT; 3-bit counter cnt.
  - IDLE: load_hit & !flush & LOAD_STALL > 1 -> LOAD_WAIT, cnt <= LOAD_STALL-1. Otherwise stay.
  - LOAD_WAIT: cnt <= cnt-1; cnt == 1 -> IDLE. flush -> IDLE, cnt <= 0.
- stall = !flush & (load_hit | state == LOAD_WAIT | sb_hit); bubble = stall.
- Scoreboard: on edge, mdu_done clears busy[mdu_done_addr]; mdu_issue with addr != 0 sets busy[mdu_waddr]. Same address in both: set wins. Clear of a non-busy entry: no effect. busy[0] is always 0.
- mdu_issue is not qualified internally; the pipeline issues only when stall=0.
- flush affects only the sequencer and stall; scoreboard is not cleared by flush.

## Timing
- Reset: state IDLE, cnt 0, busy all 0; stall/bubble 0, forward derived from inputs (00 when all we=0).
- forward, stall, bubble: zero-latency combinational from inputs and current state.
- Load-use hit: stall high exactly LOAD_STALL consecutive cycles starting in the detection cycle, independent of load_hit in later cycles.
- busy updates one edge after mdu_issue/mdu_done; a consumer waiting on mdu_done in cycle N stalls through N and releases in N+1 (result then read via WB forwarding or the regfile).
- Reset asserted mid-LOAD_WAIT: immediate return to IDLE, stall drops asynchronously.

## Test plan
- Forward priority: ex_mem, mem_wb, wb all write r5, id_ex source0=r5 -> forward[1:0]=01; drop ex_mem_we -> 10; drop mem_wb_we -> 11; addr r0 in all -> 00.
- Load-use, LOAD_STALL=3: id_ex load r7, if_id source1=r7 valid -> stall=1 for exactly 3 cycles, then 0; same with rvalid[1]=0 -> no stall.
- Load to r0 with if_id reading r0 -> stall=0.
- Flush in 2nd cycle of LOAD_STALL=3 wait -> stall=0 that cycle, state IDLE next cycle.
- Scoreboard: mdu_issue r9 cycle 0; if_id reads r9 cycles 1-4; mdu_done r9 cycle 4 -> stall 1 cycles 1-4, 0 cycle 5; mdu_issue and mdu_done r9 same cycle -> busy[9] stays 1.
- Async reset during LOAD_WAIT with busy[3]=1 -> stall 0 and busy all 0 before next clock edge.

Source files
------------

// File: rtl/hazard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_multi : EX operand forwarding, load-use stall sequencer and
//                     long-latency register scoreboard.   Rev 1.0
// ============================================================================
module hazard_ctrl_multi #(
    parameter int NUM_SRC    = 2,
    parameter int AW         = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_mem_we,
    input  logic [AW-1:0]         ex_mem_waddr,
    input  logic                  mem_wb_we,
    input  logic [AW-1:0]         mem_wb_waddr,
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_waddr,
    input  logic [NUM_SRC*AW-1:0] id_ex_raddr,
    input  logic                  id_ex_we,
    input  logic                  id_ex_is_load,
    input  logic [AW-1:0]         id_ex_waddr,
    input  logic [NUM_SRC*AW-1:0] if_id_raddr,
    input  logic [NUM_SRC-1:0]    if_id_rvalid,
    input  logic                  if_id_we,
    input  logic [AW-1:0]         if_id_waddr,
    input  logic                  mdu_issue,
    input  logic [AW-1:0]         mdu_waddr,
    input  logic                  mdu_done,
    input  logic [AW-1:0]         mdu_done_addr,
    input  logic                  flush,
    output logic [NUM_SRC*2-1:0]  forward,
    output logic                  stall,
    output logic                  bubble,
    output logic [2**AW-1:0]      busy
);

    localparam int         NREG       = 2**AW;
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic            load_hit;
    logic            load_src_match;
    logic            sb_hit;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        forward = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_we && ex_mem_waddr != '0 && ex_mem_waddr == id_ex_raddr[i*AW +: AW])
                forward[2*i +: 2] = 2'b01;
            else if (mem_wb_we && mem_wb_waddr != '0 && mem_wb_waddr == id_ex_raddr[i*AW +: AW])
                forward[2*i +: 2] = 2'b10;
            else if (wb_we && wb_waddr != '0 && wb_waddr == id_ex_raddr[i*AW +: AW])
                forward[2*i +: 2] = 2'b11;
        end
    end

    // RAW against the in-flight load and against any pending long-latency result
    always_comb begin
        load_src_match = 1'b0;
        sb_hit         = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (if_id_rvalid[i] && if_id_raddr[i*AW +: AW] == id_ex_waddr)
                load_src_match = 1'b1;
            if (if_id_rvalid[i] && busy[if_id_raddr[i*AW +: AW]])
                sb_hit = 1'b1;
        end
        if (if_id_we && if_id_waddr != '0 && busy[if_id_waddr])
            sb_hit = 1'b1;
        load_hit = id_ex_we && id_ex_is_load && (id_ex_waddr != '0) && load_src_match;
    end

    assign stall  = !flush && (load_hit || state == LOAD_WAIT || sb_hit);
    assign bubble = stall;

    // The detection cycle is the first stall cycle, so the wait covers LOAD_STALL-1 more
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_hit && !flush && (LOAD_STALL > 1)) begin
                        state <= LOAD_WAIT;
                        cnt   <= STALL_INIT;
                    end
                end
                LOAD_WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1)
                            state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Set is applied after clear so a same-address issue wins over completion
    always_comb begin
        busy_nxt = busy;
        if (mdu_done)
            busy_nxt[mdu_done_addr] = 1'b0;
        if (mdu_issue && mdu_waddr != '0)
            busy_nxt[mdu_waddr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_multi.sv
`default_nettype none
// Testbench for hazard_ctrl_multi: directed scenarios plus randomized traffic
// checked against a behavioural model of forwarding, stall windows and busy set.
module tb_hazard_ctrl_multi;

    localparam int NS  = 2;
    localparam int AWT = 5;
    localparam int LS  = 3;
    localparam int NR  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_mem_we, mem_wb_we, wb_we;
    logic [AWT-1:0]    ex_mem_waddr, mem_wb_waddr, wb_waddr;
    logic [NS*AWT-1:0] id_ex_raddr, if_id_raddr;
    logic              id_ex_we, id_ex_is_load;
    logic [AWT-1:0]    id_ex_waddr;
    logic [NS-1:0]     if_id_rvalid;
    logic              if_id_we;
    logic [AWT-1:0]    if_id_waddr;
    logic              mdu_issue, mdu_done;
    logic [AWT-1:0]    mdu_waddr, mdu_done_addr;
    logic              flush;
    logic [NS*2-1:0]   forward;
    logic              stall, bubble;
    logic [NR-1:0]     busy;

    int checks   = 0;
    int failures = 0;

    // behavioural model: remaining stall cycles owed to a detected load, and a busy set
    int wait_left;
    bit ref_busy [NR];

    hazard_ctrl_multi #(.NUM_SRC(NS), .AW(AWT), .LOAD_STALL(LS)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_we(ex_mem_we), .ex_mem_waddr(ex_mem_waddr),
        .mem_wb_we(mem_wb_we), .mem_wb_waddr(mem_wb_waddr),
        .wb_we(wb_we), .wb_waddr(wb_waddr),
        .id_ex_raddr(id_ex_raddr), .id_ex_we(id_ex_we),
        .id_ex_is_load(id_ex_is_load), .id_ex_waddr(id_ex_waddr),
        .if_id_raddr(if_id_raddr), .if_id_rvalid(if_id_rvalid),
        .if_id_we(if_id_we), .if_id_waddr(if_id_waddr),
        .mdu_issue(mdu_issue), .mdu_waddr(mdu_waddr),
        .mdu_done(mdu_done), .mdu_done_addr(mdu_done_addr),
        .flush(flush), .forward(forward), .stall(stall), .bubble(bubble), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_fwd(int i);
        logic [AWT-1:0] s;
        s = id_ex_raddr[i*AWT +: AWT];
        if (s == 0) return 2'b00;
        if (ex_mem_we && ex_mem_waddr == s) return 2'b01;
        if (mem_wb_we && mem_wb_waddr == s) return 2'b10;
        if (wb_we && wb_waddr == s) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [NS*2-1:0] exp_forward();
        logic [NS*2-1:0] v;
        for (int i = 0; i < NS; i++) v[2*i +: 2] = exp_fwd(i);
        return v;
    endfunction

    function automatic bit exp_load_hit();
        bit hit = 0;
        if (!(id_ex_we && id_ex_is_load) || id_ex_waddr == 0) return 0;
        for (int i = 0; i < NS; i++)
            if (if_id_rvalid[i] && if_id_raddr[i*AWT +: AWT] == id_ex_waddr) hit = 1;
        return hit;
    endfunction

    function automatic bit exp_sb_hit();
        bit hit = 0;
        for (int i = 0; i < NS; i++)
            if (if_id_rvalid[i] && ref_busy[int'(if_id_raddr[i*AWT +: AWT])]) hit = 1;
        if (if_id_we && if_id_waddr != 0 && ref_busy[int'(if_id_waddr)]) hit = 1;
        return hit;
    endfunction

    function automatic bit exp_stall();
        return !flush && (exp_load_hit() || wait_left > 0 || exp_sb_hit());
    endfunction

    function automatic logic [NR-1:0] exp_busy();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = ref_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        wait_left = 0;
        for (int r = 0; r < NR; r++) ref_busy[r] = 0;
    endtask

    // advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        int nxt;
        if (wait_left > 0)                  nxt = flush ? 0 : wait_left - 1;
        else if (exp_load_hit() && !flush)  nxt = LS - 1;
        else                                nxt = 0;
        if (mdu_done) ref_busy[int'(mdu_done_addr)] = 0;
        if (mdu_issue && mdu_waddr != 0) ref_busy[int'(mdu_waddr)] = 1;
        @(posedge clk);
        #1;
        if (rst) model_reset(); else wait_left = nxt;
    endtask

    task automatic clear_inputs();
        ex_mem_we = 0; ex_mem_waddr = 0; mem_wb_we = 0; mem_wb_waddr = 0;
        wb_we = 0; wb_waddr = 0; id_ex_raddr = 0; id_ex_we = 0; id_ex_is_load = 0;
        id_ex_waddr = 0; if_id_raddr = 0; if_id_rvalid = 0; if_id_we = 0; if_id_waddr = 0;
        mdu_issue = 0; mdu_waddr = 0; mdu_done = 0; mdu_done_addr = 0; flush = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        tick();
        tick();
        #2;
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: stall=%b bubble=%b expected 0 0", stall, bubble);
        end
        checks++;
        if (busy !== '0 || forward !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%h forward=%b expected 0 0", busy, forward);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_forward();
        logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        clear_inputs();
        ex_mem_we = 1; mem_wb_we = 1; wb_we = 1;
        ex_mem_waddr = 5; mem_wb_waddr = 5; wb_waddr = 5;
        id_ex_raddr[AWT-1:0] = 5;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) ex_mem_we = 0;
            if (k == 2) mem_wb_we = 0;
            if (k == 3) begin
                ex_mem_we = 1; mem_wb_we = 1; wb_we = 1;
                ex_mem_waddr = 0; mem_wb_waddr = 0; wb_waddr = 0; id_ex_raddr = 0;
            end
            #2;
            checks++;
            if (forward[1:0] !== exp_seq[k]) begin
                failures++;
                $display("FAIL forward_prio_%0d: got %b expected %b", k, forward[1:0], exp_seq[k]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        for (int pass = 0; pass < 2; pass++) begin
            clear_inputs();
            id_ex_we = 1; id_ex_is_load = 1; id_ex_waddr = 7;
            if_id_raddr[2*AWT-1:AWT] = 7;
            if_id_rvalid = (pass == 0) ? 2'b10 : 2'b00;
            for (int c = 0; c < LS + 1; c++) begin
                #2;
                checks++;
                if (stall !== ((pass == 0 && c < LS) ? 1'b1 : 1'b0) || bubble !== stall) begin
                    failures++;
                    $display("FAIL load_use_p%0d_c%0d: stall=%b bubble=%b", pass, c, stall, bubble);
                end
                tick();
                id_ex_we = 0; id_ex_is_load = 0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_r0();
        clear_inputs();
        id_ex_we = 1; id_ex_is_load = 1; id_ex_waddr = 0;
        if_id_rvalid = 2'b11;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL load_r0: stall=%b expected 0", stall);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_flush();
        logic exp_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        clear_inputs();
        id_ex_we = 1; id_ex_is_load = 1; id_ex_waddr = 12;
        if_id_raddr[AWT-1:0] = 12; if_id_rvalid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            flush = (c == 2);
            #2;
            checks++;
            if (stall !== exp_seq[c]) begin
                failures++;
                $display("FAIL flush_c%0d: stall=%b expected %b", c, stall, exp_seq[c]);
            end
            tick();
            id_ex_we = 0; id_ex_is_load = 0;
        end
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        logic exp_seq [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            mdu_issue = (c == 0); mdu_waddr = 9;
            mdu_done  = (c == 4); mdu_done_addr = 9;
            if_id_raddr[AWT-1:0] = 9;
            if_id_rvalid = (c >= 1) ? 2'b01 : 2'b00;
            #2;
            checks++;
            if (stall !== exp_seq[c]) begin
                failures++;
                $display("FAIL sb_wait_c%0d: stall=%b expected %b", c, stall, exp_seq[c]);
            end
            tick();
        end
        clear_inputs();
        mdu_issue = 1; mdu_waddr = 9; mdu_done = 1; mdu_done_addr = 9;
        tick();
        clear_inputs();
        #2;
        checks++;
        if (busy[9] !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins: busy[9]=%b expected 1", busy[9]);
        end
        mdu_done = 1; mdu_done_addr = 9;
        tick();
        clear_inputs();
        #2;
        checks++;
        if (busy[9] !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: busy[9]=%b expected 0", busy[9]);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        mdu_issue = 1; mdu_waddr = 3;
        tick();
        clear_inputs();
        id_ex_we = 1; id_ex_is_load = 1; id_ex_waddr = 7;
        if_id_raddr[2*AWT-1:AWT] = 7; if_id_rvalid = 2'b10;
        tick();
        clear_inputs();
        #2;
        checks++;
        if (stall !== 1'b1 || busy[3] !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: stall=%b busy[3]=%b expected 1 1", stall, busy[3]);
        end
        #1 rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== '0) begin
            failures++;
            $display("FAIL async_reset: stall=%b busy=%h expected 0 0", stall, busy);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        tick();
    endtask

    task automatic test_random();
        logic [NS*2-1:0] ef;
        logic [NR-1:0]   eb;
        bit              es;
        for (int n = 0; n < 400; n++) begin
            ex_mem_we = 1'($urandom); ex_mem_waddr = 5'($urandom_range(0, 7));
            mem_wb_we = 1'($urandom); mem_wb_waddr = 5'($urandom_range(0, 7));
            wb_we = 1'($urandom);     wb_waddr = 5'($urandom_range(0, 7));
            for (int i = 0; i < NS; i++) begin
                id_ex_raddr[i*AWT +: AWT] = 5'($urandom_range(0, 7));
                if_id_raddr[i*AWT +: AWT] = 5'($urandom_range(0, 7));
            end
            if_id_rvalid = 2'($urandom);
            id_ex_we = 1'($urandom); id_ex_is_load = ($urandom_range(0, 2) == 0);
            id_ex_waddr = 5'($urandom_range(0, 7));
            if_id_we = 1'($urandom); if_id_waddr = 5'($urandom_range(0, 7));
            mdu_issue = ($urandom_range(0, 3) == 0); mdu_waddr = 5'($urandom_range(0, 7));
            mdu_done = ($urandom_range(0, 2) == 0);  mdu_done_addr = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 7) == 0);
            #2;
            ef = exp_forward(); es = exp_stall(); eb = exp_busy();
            checks++;
            if (forward !== ef) begin
                failures++;
                $display("FAIL rand_forward_%0d: got %b expected %b", n, forward, ef);
            end
            checks++;
            if (stall !== es || bubble !== es) begin
                failures++;
                $display("FAIL rand_stall_%0d: stall=%b bubble=%b expected %b", n, stall, bubble, es);
            end
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL rand_busy_%0d: got %h expected %h", n, busy, eb);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_load_r0();
        test_flush();
        test_scoreboard();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
